// File: rtl/wave_seq_pkg.sv
// Shared types and default widths for the wave sample sequencer.
// Imported by the interface, the tick generator and the sequencer top.
package wave_seq_pkg;

   localparam int DEF_DW = 16;
   localparam int DEF_RW = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      REQ,
      OUT
   } state_t;

endpackage

// File: rtl/wave_sample_sequencer_if.sv
// Compute-unit request/ack bus and sample stream bundled together.
// master = sequencer side, slave = compute unit + readout side.
interface wave_sample_sequencer_if
   import wave_seq_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int RW = DEF_RW
);

   logic [DW-1:0] calc_amp;
   logic [DW-1:0] calc_freq;
   logic [DW-1:0] calc_phase;
   logic [DW-1:0] calc_t;
   logic          calc_req;
   logic          calc_ack;
   logic [RW-1:0] calc_result;
   logic          smp_valid;
   logic [DW-1:0] smp_data;
   logic          smp_ready;

   modport master (
      output calc_amp, calc_freq, calc_phase, calc_t, calc_req,
      input  calc_ack, calc_result,
      output smp_valid, smp_data,
      input  smp_ready
   );

   modport slave (
      input  calc_amp, calc_freq, calc_phase, calc_t, calc_req,
      output calc_ack, calc_result,
      input  smp_valid, smp_data,
      output smp_ready
   );

endinterface

// File: rtl/wave_tick_gen.sv
// Sample-rate divider: one tick every max(div,1) enabled cycles.
// clear holds the count at zero so the first tick lands div cycles later.
module wave_tick_gen
   import wave_seq_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clear,
   input  logic [DW-1:0] div,
   output logic          tick
);

   localparam logic [DW-1:0] ONE = DW'(1);

   logic [DW-1:0] cnt;
   logic [DW-1:0] term;

   assign term = (div == '0) ? '0 : div - ONE;
   assign tick = en && (cnt == term);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + ONE;
      end
   end

endmodule

// File: rtl/wave_sample_sequencer.sv
// Burst sequencer for the wave compute unit: latches config on start,
// paces t with the tick divider, and streams result[RW-1 -: DW] out.
module wave_sample_sequencer
   import wave_seq_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int RW = DEF_RW
) (
   input  logic                    ti_clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [DW-1:0]           amp_in,
   input  logic [DW-1:0]           freq_in,
   input  logic [DW-1:0]           phase_in,
   input  logic [DW-1:0]           num_samples,
   input  logic [DW-1:0]           rate_div,
   wave_sample_sequencer_if.master bus,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   localparam logic [DW-1:0] ONE = DW'(1);

   state_t state, state_n;

   logic [DW-1:0] amp_r, freq_r, phase_r;
   logic [DW-1:0] num_r, div_r, t_r, data_r;
   logic          pend, ovr_r, done_r, tick, last;
   logic          load, take, inc_t;
   logic          set_pend, clr_pend, done_n;

   wave_tick_gen #(.DW(DW)) u_tick (
      .clk   (ti_clk),
      .rst_n (rst_n),
      .en    (state != IDLE),
      .clear (state == IDLE),
      .div   (div_r),
      .tick  (tick)
   );

   assign last = (t_r == num_r - ONE);

   always_ff @(posedge ti_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      load     = 1'b0;
      take     = 1'b0;
      inc_t    = 1'b0;
      set_pend = 1'b0;
      clr_pend = 1'b0;
      done_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               if (num_samples != '0) state_n = WAIT_TICK;
               else                   done_n  = 1'b1;
            end
         end
         WAIT_TICK: begin
            if (tick || pend) begin
               clr_pend = 1'b1;
               state_n  = REQ;
            end
         end
         REQ: begin
            set_pend = tick;
            if (bus.calc_ack) begin
               take    = 1'b1;
               state_n = OUT;
            end
         end
         OUT: begin
            set_pend = tick;
            if (bus.smp_ready) begin
               if (last) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  inc_t   = 1'b1;
                  state_n = WAIT_TICK;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // abort beats everything, including a start seen in IDLE
      if (abort) begin
         state_n  = IDLE;
         load     = 1'b0;
         take     = 1'b0;
         inc_t    = 1'b0;
         set_pend = 1'b0;
         clr_pend = 1'b1;
         done_n   = 1'b0;
      end
   end

   always_ff @(posedge ti_clk) begin
      if (!rst_n) begin
         amp_r   <= '0;
         freq_r  <= '0;
         phase_r <= '0;
         num_r   <= '0;
         div_r   <= '0;
         t_r     <= '0;
         data_r  <= '0;
         pend    <= 1'b0;
         ovr_r   <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= done_n;
         if (load) begin
            amp_r   <= amp_in;
            freq_r  <= freq_in;
            phase_r <= phase_in;
            num_r   <= num_samples;
            div_r   <= rate_div;
            t_r     <= '0;
            ovr_r   <= 1'b0;
         end else if (set_pend) begin
            ovr_r <= 1'b1;
         end
         if (load || clr_pend) pend <= 1'b0;
         else if (set_pend)    pend <= 1'b1;
         if (take)  data_r <= bus.calc_result[RW-1 -: DW];
         if (inc_t) t_r    <= t_r + ONE;
      end
   end

   assign bus.calc_amp   = amp_r;
   assign bus.calc_freq  = freq_r;
   assign bus.calc_phase = phase_r;
   assign bus.calc_t     = t_r;
   assign bus.calc_req   = (state == REQ);
   assign bus.smp_valid  = (state == OUT);
   assign bus.smp_data   = data_r;

   assign busy    = (state != IDLE);
   assign done    = done_r;
   assign overrun = ovr_r;

endmodule

// File: tb/tb_wave_sample_sequencer.sv
// Scoreboard bench: a compute/readout model acks requests, queues the
// expected sample and checks it when the stream hands it over.
module tb_wave_sample_sequencer;
   import wave_seq_pkg::*;

   localparam int DW = DEF_DW;
   localparam int RW = DEF_RW;

   logic          ti_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] amp_in = '0;
   logic [DW-1:0] freq_in = '0;
   logic [DW-1:0] phase_in = '0;
   logic [DW-1:0] num_samples = '0;
   logic [DW-1:0] rate_div = '0;
   logic          busy, done, overrun;

   wave_sample_sequencer_if #(.DW(DW), .RW(RW)) bus ();

   wave_sample_sequencer #(.DW(DW), .RW(RW)) dut (
      .ti_clk      (ti_clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .amp_in      (amp_in),
      .freq_in     (freq_in),
      .phase_in    (phase_in),
      .num_samples (num_samples),
      .rate_div    (rate_div),
      .bus         (bus),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   always #5 ti_clk = ~ti_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int            ack_dly = 0;
   int            ready_dly = 0;
   bit            drop_ok = 1'b0;
   logic [DW-1:0] cfg_amp = '0;
   logic [DW-1:0] cfg_freq = '0;
   logic [DW-1:0] cfg_phase = '0;
   int            done_cnt = 0;
   int            smp_cnt = 0;
   int            req_seen = 0;
   int            busy_seen = 0;
   logic [DW-1:0] q[$];

   function automatic logic [DW-1:0] model(input logic [DW-1:0] a,
                                           input logic [DW-1:0] p,
                                           input logic [DW-1:0] t);
      return (a ^ p) + (t * 16'h0123);
   endfunction

   // compute unit + readout sink
   initial begin
      logic [DW-1:0] exp_t;
      logic [DW-1:0] h;
      int            req_cnt;
      int            hold;
      exp_t = '0;
      req_cnt = 0;
      hold = 0;
      bus.calc_ack = 1'b0;
      bus.calc_result = '0;
      bus.smp_ready = 1'b0;
      forever begin
         @(negedge ti_clk);
         if (done) done_cnt++;
         if (bus.calc_req) req_seen++;
         if (busy) busy_seen++;
         if (!busy) begin
            exp_t = '0;
            if (q.size() != 0) begin
               if (!drop_ok) chk("q_left", q.size(), 0);
               q.delete();
            end
         end
         if (bus.calc_req) begin
            if (req_cnt == ack_dly) begin
               h = model(cfg_amp, cfg_phase, exp_t);
               bus.calc_ack = 1'b1;
               bus.calc_result = {h, ~h ^ exp_t};
               chk("calc_t", bus.calc_t, exp_t);
               chk("calc_amp", bus.calc_amp, cfg_amp);
               chk("calc_freq", bus.calc_freq, cfg_freq);
               chk("calc_phase", bus.calc_phase, cfg_phase);
               q.push_back(h);
               exp_t++;
               req_cnt = 0;
            end else begin
               bus.calc_ack = 1'b0;
               req_cnt++;
            end
         end else begin
            bus.calc_ack = 1'b0;
            bus.calc_result = '0;
            req_cnt = 0;
         end
         if (bus.smp_valid) begin
            if (hold < ready_dly) begin
               bus.smp_ready = 1'b0;
               hold++;
            end else begin
               bus.smp_ready = 1'b1;
               hold = 0;
               smp_cnt++;
               if (q.size() == 0) chk("smp_extra", 1, 0);
               else chk("smp_data", bus.smp_data, q.pop_front());
            end
         end else begin
            bus.smp_ready = 1'b0;
            hold = 0;
         end
      end
   end

   task automatic tick1();
      @(negedge ti_clk);
      #1;
   endtask

   task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] f,
                         input logic [DW-1:0] p, input logic [DW-1:0] n,
                         input logic [DW-1:0] d);
      amp_in = a;
      freq_in = f;
      phase_in = p;
      num_samples = n;
      rate_div = d;
      cfg_amp = a;
      cfg_freq = f;
      cfg_phase = p;
      start = 1'b1;
      tick1();
      start = 1'b0;
   endtask

   task automatic wait_req(output int lat);
      lat = 1;
      while (!bus.calc_req && lat < 100) begin
         tick1();
         lat++;
      end
      if (!bus.calc_req) chk("req_timeout", 0, 1);
   endtask

   task automatic wait_valid(input int max);
      int n;
      n = 0;
      while (!bus.smp_valid && n < max) begin
         tick1();
         n++;
      end
      if (!bus.smp_valid) chk("valid_timeout", 0, 1);
   endtask

   task automatic wait_done(input int max);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < max) begin
         tick1();
         n++;
      end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      else chk("done_busy", busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, d0, s0, r0, b0;
      repeat (3) tick1();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_req", bus.calc_req, 0);
      chk("rst_valid", bus.smp_valid, 0);
      chk("rst_t", bus.calc_t, 0);
      chk("rst_amp", bus.calc_amp, 0);
      chk("rst_data", bus.smp_data, 0);
      rst_n = 1'b1;
      tick1();

      // reset while in REQ
      ack_dly = 50;
      launch(16'h1111, 16'h2222, 16'h3333, 16'd4, 16'd2);
      wait_req(lat);
      chk("a_lat", lat, 3);
      d0 = done_cnt;
      rst_n = 1'b0;
      tick1();
      chk("a_busy", busy, 0);
      chk("a_req", bus.calc_req, 0);
      chk("a_amp", bus.calc_amp, 0);
      chk("a_phase", bus.calc_phase, 0);
      chk("a_done", done, 0);
      rst_n = 1'b1;
      repeat (2) tick1();
      chk("a_nodone", done_cnt - d0, 0);

      // normal burst, div=3
      ack_dly = 0;
      ready_dly = 0;
      d0 = done_cnt;
      s0 = smp_cnt;
      launch(16'hA5A5, 16'h0F0F, 16'h1234, 16'd4, 16'd3);
      wait_req(lat);
      chk("b_lat", lat, 4);
      wait_done(200);
      repeat (3) tick1();
      chk("b_samples", smp_cnt - s0, 4);
      chk("b_done_once", done_cnt - d0, 1);
      chk("b_ovr", overrun, 0);

      // empty burst
      r0 = req_seen;
      b0 = busy_seen;
      d0 = done_cnt;
      launch(16'h5555, 16'h6666, 16'h7777, 16'd0, 16'd3);
      chk("c_done", done, 1);
      chk("c_busy", busy, 0);
      repeat (5) tick1();
      chk("c_req", req_seen - r0, 0);
      chk("c_busy_seen", busy_seen - b0, 0);
      chk("c_done_cnt", done_cnt - d0, 1);

      // slow ack + stalled sink at div=1
      ack_dly = 5;
      ready_dly = 4;
      d0 = done_cnt;
      s0 = smp_cnt;
      launch(16'h0001, 16'h0002, 16'h0003, 16'd3, 16'd1);
      wait_done(300);
      chk("d_samples", smp_cnt - s0, 3);
      chk("d_done", done_cnt - d0, 1);
      chk("d_ovr", overrun, 1);

      // abort with a sample on the stream
      ack_dly = 0;
      ready_dly = 1000;
      d0 = done_cnt;
      launch(16'hBEEF, 16'h0102, 16'h0304, 16'd3, 16'd10);
      chk("e_ovr_clr", overrun, 0);
      wait_valid(100);
      abort = 1'b1;
      drop_ok = 1'b1;
      tick1();
      abort = 1'b0;
      chk("e_valid", bus.smp_valid, 0);
      chk("e_busy", busy, 0);
      chk("e_req", bus.calc_req, 0);
      chk("e_done", done, 0);
      chk("e_amp_kept", bus.calc_amp, 16'hBEEF);
      chk("e_ovr", overrun, 0);
      tick1();
      drop_ok = 1'b0;
      chk("e_nodone", done_cnt - d0, 0);
      ready_dly = 0;
      s0 = smp_cnt;
      launch(16'h4321, 16'h0A0A, 16'h0B0B, 16'd2, 16'd2);
      wait_done(200);
      chk("e_samples", smp_cnt - s0, 2);
      chk("e_done2", done_cnt - d0, 1);

      // div=0 runs as div=1; mid-burst start ignored
      d0 = done_cnt;
      s0 = smp_cnt;
      launch(16'h7777, 16'h0808, 16'h0909, 16'd5, 16'd0);
      wait_req(lat);
      chk("f_lat", lat, 2);
      amp_in = 16'hDEAD;
      num_samples = 16'd1;
      start = 1'b1;
      tick1();
      start = 1'b0;
      wait_done(200);
      chk("f_samples", smp_cnt - s0, 5);
      chk("f_done", done_cnt - d0, 1);
      chk("f_amp", bus.calc_amp, 16'h7777);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
